// File: rtl/dadder_dp_sched.sv
// rtl/dadder_dp_sched.sv - round-robin scheduler sharing one dadder datapath between requesters
module dadder_dp_sched #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic                        dp_in_valid,
    input  logic                        dp_in_ready,
    output logic [DATA_W-1:0]           dp_in_a,
    output logic [DATA_W-1:0]           dp_in_b,
    input  logic                        dp_out_valid,
    input  logic [DATA_W-1:0]           dp_out_sum,
    input  logic                        dp_out_carry,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_sum,
    output logic                        rsp_carry,
    output logic [$clog2(MAX_OUTST):0]  outst_cnt,
    output logic                        busy,
    output logic                        err_orphan
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTST);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  hold_id;
    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic             handshake;
    logic             space_ok;
    logic             grant;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ID_W-1:0]  id_mem [MAX_OUTST];

    assign handshake = dp_in_valid && dp_in_ready;
    // The slot being freed by this cycle's pop is deliberately not counted.
    assign space_ok  = (int'(outst_cnt) + int'(handshake)) < MAX_OUTST;
    // A new operation may only load when the holding register is empty or draining now.
    assign grant     = en && win_found && space_ok && (!dp_in_valid || handshake);
    assign push      = handshake;
    assign pop       = dp_out_valid && (outst_cnt != '0);
    assign busy      = dp_in_valid || (outst_cnt != '0);

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    // One-hot accept for the winner, only in a cycle where the grant actually happens.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // Issue FSM: holding register, RR pointer and registered dp_in interface.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dp_in_valid <= 1'b0;
            dp_in_a     <= '0;
            dp_in_b     <= '0;
            hold_id     <= '0;
            rr_ptr      <= '0;
        end else begin
            if (grant) begin
                dp_in_a <= req_a[int'(win_id)*DATA_W +: DATA_W];
                dp_in_b <= req_b[int'(win_id)*DATA_W +: DATA_W];
                hold_id <= win_id;
                rr_ptr  <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (grant) begin
                        state       <= ISSUE;
                        dp_in_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (dp_in_ready && !grant) begin
                        state       <= IDLE;
                        dp_in_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    dp_in_valid <= 1'b0;
                end
            endcase
        end
    end

    // ID FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr] <= hold_id;
        end
    end

    // ID FIFO pointers and in-flight count; simultaneous push/pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            outst_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                outst_cnt <= outst_cnt + 1'b1;
            end else if (pop && !push) begin
                outst_cnt <= outst_cnt - 1'b1;
            end
        end
    end

    // Route each result to the FIFO head owner one cycle later; flag results with no owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid  <= '0;
            rsp_sum    <= '0;
            rsp_carry  <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (pop) begin
                rsp_valid[id_mem[rd_ptr]] <= 1'b1;
                rsp_sum                   <= dp_out_sum;
                rsp_carry                 <= dp_out_carry;
            end
            if (dp_out_valid && (outst_cnt == '0)) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule
